sys_array_tiled: RTL and testbench
==================================

SYS_ARRAY_TILED -- requirements
Module: sys_array_tiled

Interface
REQ-001 SHALL have parameter N, default 4: array is N x N PEs, N >= 2.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: operand width, two's-complement signed.
REQ-003 SHALL have parameter ACC_WIDTH, default 32: accumulator width; elaboration SHALL fail if ACC_WIDTH < 2*DATA_WIDTH.
REQ-004 SHALL have parameter K_MAX, default 256: maximum reduction length; KW = $clog2(K_MAX+1).
REQ-005 SHALL have ports, in order:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- start  in  1  job request, sampled in IDLE only.
- k_len  in  KW  reduction length, latched with start, range 0..K_MAX.
- bias  in  [N][ACC_WIDTH]  per-column bias, latched with start.
- in_valid  in  1  a_vec/b_vec beat valid.
- in_ready  out  1  block accepts a beat.
- a_vec  in  [N][DATA_WIDTH]  column k of A, one element per row.
- b_vec  in  [N][DATA_WIDTH]  row k of B, one element per column.
- out_valid  out  1  out_row valid.
- out_ready  in  1  consumer accepts out_row.
- out_row  out  [N][ACC_WIDTH]  result row C[r][0..N-1].
- out_row_idx  out  $clog2(N)  r of current out_row.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last row is accepted.

Function
REQ-006 SHALL compute C[i][j] = bias[j] + sum over k of a_k[i]*b_k[j] (output-stationary).
REQ-007 Each product SHALL be signed 2*DATA_WIDTH, sign-extended to ACC_WIDTH; accumulation SHALL wrap modulo 2^ACC_WIDTH, with no saturation.
REQ-008 FSM states SHALL be IDLE, LOAD, FEED, FLUSH, DRAIN.
REQ-009 IDLE -> LOAD on start=1; the block SHALL latch k_len and bias.
REQ-010 LOAD SHALL last 1 cycle: acc[i][j] <= bias[j]; skew registers and PE pipes cleared to 0.
REQ-011 LOAD -> FEED if k_len > 0, else LOAD -> DRAIN directly.
REQ-012 In FEED, in_ready SHALL be 1; a beat transfers on in_valid && in_ready; the beat counter increments on transfer only.
REQ-013 Row i of a_vec SHALL be delayed i cycles and column j of b_vec j cycles by internal skew registers before entering the array.
REQ-014 Cycles in FEED without a transfer SHALL inject zeros, so bubbles do not alter the result.
REQ-015 FEED -> FLUSH in the cycle the k_len-th beat transfers; in_ready SHALL be 0 in every state except FEED.
REQ-016 FLUSH SHALL last exactly 2N-1 cycles, injecting zeros, then go to DRAIN; accumulators are final on entry to DRAIN.
REQ-017 In DRAIN, out_valid SHALL be 1, with out_row = acc[r] and out_row_idx = r, starting at r = 0.
REQ-018 In DRAIN, r SHALL increment on out_valid && out_ready.
REQ-019 With out_ready = 0 in DRAIN, out_row and out_row_idx SHALL hold stable.
REQ-020 Acceptance of row N-1 SHALL cause DRAIN -> IDLE and done = 1 for exactly the next cycle.
REQ-021 start SHALL be ignored while busy = 1; start in the same cycle as done SHALL be honoured, since the FSM is then in IDLE.
REQ-022 Latency from the last FEED transfer to first out_valid SHALL be 2N cycles, given 2N-1 FLUSH cycles plus the transition.

Reset
REQ-023 With rst = 0 at a clock edge, the next cycle SHALL show:
- state IDLE; all accumulators, skew registers, PE pipes, counters and latched bias = 0;
- in_ready = 0, out_valid = 0, busy = 0, done = 0, out_row = 0, out_row_idx = 0.
REQ-024 Reset mid-job in any state SHALL abort the job with no further output; a new start after reset SHALL run normally.

Structure
REQ-025 Package sys_array_pkg SHALL hold the state enum type and the FLUSH length function 2N-1.
REQ-026 One sub-module, mac_pe, SHALL be used: registered a/b pass-through, clear/load-bias input, signed MAC into ACC_WIDTH; instantiated N*N times via generate.
REQ-027 Skew registers, FSM, counters and drain mux SHALL reside in sys_array_tiled.

Verification
REQ-028 N=4, A=I4, B rows {1,2,3,4},{5..8},{9..12},{13..16}, bias 0, k_len=4 -> rows equal B, out_row_idx 0..3, one done pulse.
REQ-029 k_len=0, bias {10,20,30,40} -> no FEED cycles, in_ready never 1; four rows each {10,20,30,40}.
REQ-030 All a = b = -128, k_len=256, bias -1 -> every element 4194303; repeat with all a = 127, b = -128, k_len=256, bias 0 -> every element -4161536.
REQ-031 Scenario 1 with in_valid toggling every cycle, plus out_ready = 0 for 5 cycles at row 1 -> identical results; row 1 held stable; no row lost or duplicated.
REQ-032 rst = 0 for 1 cycle mid-FEED, then start asserted mid-job -> busy, out_valid = 0 next cycle; a new scenario-1 job completes correctly.

Source files
------------

// File: rtl/sys_array_pkg.sv
// Shared FSM state type and phase-length helper for the tiled systolic array.
// Pure declarations: no logic, no latency, no flow control.
package sys_array_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FEED,
    ST_FLUSH,
    ST_DRAIN
  } state_e;

  // Cycles needed for the last injected beat to cross the whole N x N array.
  function automatic int flush_len(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/mac_pe.sv
// One output-stationary PE: registered a/b pass-through, signed MAC into ACC_WIDTH.
// One-cycle operand forwarding; no backpressure, en/clr are driven by the array FSM.
module mac_pe #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [ACC_WIDTH-1:0]  bias_in,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic [ACC_WIDTH-1:0]  acc_out
);

  logic [DATA_WIDTH-1:0]         a_q, a_d, b_q, b_d;
  logic [ACC_WIDTH-1:0]          acc_q, acc_d;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]   prod_ext;

  always_comb begin
    prod     = (2*DATA_WIDTH)'($signed(a_in)) * (2*DATA_WIDTH)'($signed(b_in));
    prod_ext = ACC_WIDTH'(prod);
    a_d      = clr ? '0 : a_in;
    b_d      = clr ? '0 : b_in;
    acc_d    = acc_q;
    if (clr) begin
      acc_d = bias_in;
    end else if (en) begin
      // Wraps modulo 2^ACC_WIDTH by construction.
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_out   = a_q;
  assign b_out   = b_q;
  assign acc_out = acc_q;

endmodule

// File: rtl/sys_array_tiled.sv
// N x N output-stationary systolic matmul with skewed feed, flush and row-serial drain.
// First row 2N cycles after the last beat; in_ready only in FEED, rows hold while out_ready=0.
module sys_array_tiled
  import sys_array_pkg::*;
#(
  parameter  int N          = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int ACC_WIDTH  = 32,
  parameter  int K_MAX      = 256,
  localparam int KW         = $clog2(K_MAX + 1),
  localparam int RW         = $clog2(N)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [KW-1:0]                    k_len,
  input  logic [N-1:0][ACC_WIDTH-1:0]      bias,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [N-1:0][DATA_WIDTH-1:0]     a_vec,
  input  logic [N-1:0][DATA_WIDTH-1:0]     b_vec,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [N-1:0][ACC_WIDTH-1:0]      out_row,
  output logic [RW-1:0]                    out_row_idx,
  output logic                             busy,
  output logic                             done
);

  localparam int            FW         = $clog2(2 * N);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(flush_len(N) - 1);

  if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_bad_acc
    $error("sys_array_tiled: ACC_WIDTH must be at least 2*DATA_WIDTH");
  end
  if (N < 2) begin : g_bad_n
    $error("sys_array_tiled: N must be at least 2");
  end

  state_e                        state_q, state_d;
  logic [KW-1:0]                 k_len_q, k_len_d, beat_cnt_q, beat_cnt_d;
  logic [N-1:0][ACC_WIDTH-1:0]   bias_q, bias_d;
  logic [FW-1:0]                 flush_cnt_q, flush_cnt_d;
  logic [RW-1:0]                 row_q, row_d;
  logic                          done_q, done_d;
  logic                          xfer, pe_clr, pe_en;

  logic [N-1:0][DATA_WIDTH-1:0]  inj_a, inj_b;
  logic [DATA_WIDTH-1:0]         skew_a [N];
  logic [DATA_WIDTH-1:0]         skew_b [N];
  logic [DATA_WIDTH-1:0]         a_h [N][N+1];
  logic [DATA_WIDTH-1:0]         b_v [N+1][N];
  logic [ACC_WIDTH-1:0]          acc [N][N];

  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    bias_d      = bias_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    row_d       = row_q;
    done_d      = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    pe_clr      = 1'b0;
    pe_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          k_len_d = k_len;
          bias_d  = bias;
        end
      end
      ST_LOAD: begin
        pe_clr      = 1'b1;
        beat_cnt_d  = '0;
        flush_cnt_d = '0;
        row_d       = '0;
        state_d     = (k_len_q != '0) ? ST_FEED : ST_DRAIN;
      end
      ST_FEED: begin
        in_ready = 1'b1;
        pe_en    = 1'b1;
        if (in_valid) begin
          beat_cnt_d = beat_cnt_q + KW'(1);
          if (beat_cnt_d == k_len_q) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        pe_en       = 1'b1;
        flush_cnt_d = flush_cnt_q + FW'(1);
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d = ST_DRAIN;
          row_d   = '0;
        end
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (row_q == RW'(N - 1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            row_d   = '0;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      k_len_q     <= '0;
      bias_q      <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      row_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      bias_q      <= bias_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      row_q       <= row_d;
      done_q      <= done_d;
    end
  end

  // Idle and stalled cycles push zeros so they contribute nothing to the sums.
  assign xfer  = in_valid && in_ready;
  assign inj_a = xfer ? a_vec : '0;
  assign inj_b = xfer ? b_vec : '0;

  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign skew_a[0] = inj_a[0];
      assign skew_b[0] = inj_b[0];
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] sa_q [i];
      logic [DATA_WIDTH-1:0] sa_d [i];
      logic [DATA_WIDTH-1:0] sb_q [i];
      logic [DATA_WIDTH-1:0] sb_d [i];

      always_comb begin
        sa_d[0] = pe_clr ? '0 : inj_a[i];
        sb_d[0] = pe_clr ? '0 : inj_b[i];
        for (int d = 1; d < i; d++) begin
          sa_d[d] = pe_clr ? '0 : sa_q[d-1];
          sb_d[d] = pe_clr ? '0 : sb_q[d-1];
        end
      end

      always_ff @(posedge clk) begin
        for (int d = 0; d < i; d++) begin
          if (!rst) begin
            sa_q[d] <= '0;
            sb_q[d] <= '0;
          end else begin
            sa_q[d] <= sa_d[d];
            sb_q[d] <= sb_d[d];
          end
        end
      end

      assign skew_a[i] = sa_q[i-1];
      assign skew_b[i] = sb_q[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    assign a_h[i][0] = skew_a[i];
    assign b_v[0][i] = skew_b[i];
    for (genvar j = 0; j < N; j++) begin : g_col
      mac_pe #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
      ) u_pe (
        .clk    (clk),
        .rst    (rst),
        .clr    (pe_clr),
        .en     (pe_en),
        .bias_in(bias_q[j]),
        .a_in   (a_h[i][j]),
        .b_in   (b_v[i][j]),
        .a_out  (a_h[i][j+1]),
        .b_out  (b_v[i+1][j]),
        .acc_out(acc[i][j])
      );
    end
  end

  always_comb begin
    out_row = '0;
    if (state_q == ST_DRAIN) begin
      for (int j = 0; j < N; j++) begin
        out_row[j] = acc[row_q][j];
      end
    end
  end

  assign out_row_idx = row_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;

endmodule

// File: tb/tb_sys_array_tiled.sv
// Bench for sys_array_tiled: job table plus hand sequences, rows checked against a scoreboard.
module tb_sys_array_tiled;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int AW   = 32;
  localparam int KMAX = 256;
  localparam int KW   = $clog2(KMAX + 1);
  localparam int RW   = $clog2(N);

  typedef logic [N-1:0][AW-1:0] row_t;
  typedef struct {
    int   k;
    int   a_val;
    int   b_val;
    row_t bias_v;
    row_t exp_v;
  } vec_t;
  typedef struct {
    row_t row;
    int   idx;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [KW-1:0]        k_len;
  row_t                 bias;
  logic                 in_valid;
  logic                 in_ready;
  logic [N-1:0][DW-1:0] a_vec;
  logic [N-1:0][DW-1:0] b_vec;
  logic                 out_valid;
  logic                 out_ready;
  row_t                 out_row;
  logic [RW-1:0]        out_row_idx;
  logic                 busy;
  logic                 done;

  sys_array_tiled #(
    .N         (N),
    .DATA_WIDTH(DW),
    .ACC_WIDTH (AW),
    .K_MAX     (KMAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .k_len      (k_len),
    .bias       (bias),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_vec      (a_vec),
    .b_vec      (b_vec),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_row    (out_row),
    .out_row_idx(out_row_idx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        sb[$];
  logic [DW-1:0] a_mem [KMAX][N];
  logic [DW-1:0] b_mem [KMAX][N];
  bit          ready_seen;

  task automatic check(input string name, input logic [N*AW-1:0] act, input logic [N*AW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic row_t mk_row(input int c0, input int c1, input int c2, input int c3);
    row_t r;
    r[0] = AW'(c0);
    r[1] = AW'(c1);
    r[2] = AW'(c2);
    r[3] = AW'(c3);
    return r;
  endfunction

  // Scoreboard side: every accepted row must match the oldest expectation.
  always @(negedge clk) begin
    if (in_ready) ready_seen = 1'b1;
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_row: got row %0d, required no row", out_row_idx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("row_data", out_row, e.row);
        check("row_idx", out_row_idx, e.idx);
      end
    end
  end

  task automatic fill_const(input int klen, input int av, input int bv);
    for (int k = 0; k < klen; k++) begin
      for (int i = 0; i < N; i++) begin
        a_mem[k][i] = DW'(av);
        b_mem[k][i] = DW'(bv);
      end
    end
  endtask

  task automatic fill_ident();
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        a_mem[k][i] = (i == k) ? DW'(1) : DW'(0);
        b_mem[k][i] = DW'(4 * k + i + 1);
      end
    end
  endtask

  task automatic push_model(input int klen, input row_t b_in);
    for (int i = 0; i < N; i++) begin
      exp_t e;
      e.idx = i;
      for (int j = 0; j < N; j++) begin
        int s;
        s = int'(b_in[j]);
        for (int k = 0; k < klen; k++) begin
          s += int'($signed(a_mem[k][i])) * int'($signed(b_mem[k][j]));
        end
        e.row[j] = AW'(s);
      end
      sb.push_back(e);
    end
  endtask

  task automatic push_table(input row_t r);
    for (int i = 0; i < N; i++) begin
      exp_t e;
      e.row = r;
      e.idx = i;
      sb.push_back(e);
    end
  endtask

  task automatic run_job(input int klen, input row_t bias_in, input bit toggle,
                         input int stall_row, input int stall_cyc, input bit hold_start);
    int k, guard, lat, stall_left, n_done;
    bit xfer;
    ready_seen = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    k_len = KW'(klen);
    bias  = bias_in;
    @(posedge clk); #1;
    start = hold_start;
    @(negedge clk);
    check("busy_after_start", busy, 1);
    check("no_out_in_load", out_valid, 0);
    k = 0;
    guard = 0;
    while (k < klen && guard < 4 * KMAX + 16) begin
      in_valid = toggle ? ((guard % 2) == 1) : 1'b1;
      for (int i = 0; i < N; i++) begin
        a_vec[i] = in_valid ? a_mem[k][i] : DW'(8'h5A);
        b_vec[i] = in_valid ? b_mem[k][i] : DW'(8'hA7);
      end
      @(negedge clk);
      xfer = in_valid && in_ready;
      @(posedge clk); #1;
      if (xfer) k++;
      guard++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("beats_sent", k, klen);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 600);
    if (klen > 0) check("first_row_latency", lat, 2 * N);
    else          check("in_ready_never", ready_seen, 0);
    stall_left = stall_cyc;
    n_done = 0;
    guard = 0;
    while (n_done == 0 && guard < 64) begin
      @(posedge clk); #1;
      out_ready = !(out_valid && out_row_idx == RW'(stall_row) && stall_left > 0);
      @(negedge clk);
      if (done) n_done++;
      if (!out_ready) begin
        stall_left--;
        if (sb.size() > 0) begin
          check("stall_row_hold", out_row, sb[0].row);
          check("stall_idx_hold", out_row_idx, sb[0].idx);
        end
      end
      guard++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("done_seen", n_done, 1);
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
    check("stall_cycles_used", stall_left, 0);
    check("scoreboard_empty", sb.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    int   seen;
    tbl[0] = '{0,    0,    0,    mk_row(10, 20, 30, 40),   mk_row(10, 20, 30, 40)};
    tbl[1] = '{256, -128, -128,  mk_row(-1, -1, -1, -1),   mk_row(4194303, 4194303, 4194303, 4194303)};
    tbl[2] = '{256,  127, -128,  mk_row(0, 0, 0, 0),       mk_row(-4161536, -4161536, -4161536, -4161536)};
    tbl[3] = '{3,    2,   -3,    mk_row(0, 1, 2, 3),       mk_row(-18, -17, -16, -15)};
    tbl[4] = '{1,   -1,   -1,    mk_row(100, -100, 0, 7),  mk_row(101, -99, 1, 8)};

    rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    k_len = '0; bias = '0; a_vec = '0; b_vec = '0;
    @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_out_row", out_row, 0);
    check("reset_row_idx", out_row_idx, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int t = 0; t < 5; t++) begin
      fill_const(tbl[t].k, tbl[t].a_val, tbl[t].b_val);
      push_table(tbl[t].exp_v);
      run_job(tbl[t].k, tbl[t].bias_v, 1'b0, 0, 0, 1'b0);
    end

    fill_ident();
    push_model(4, '0);
    run_job(4, '0, 1'b0, 0, 0, 1'b0);

    push_model(4, '0);
    run_job(4, '0, 1'b1, 1, 5, 1'b0);

    // Abort a job mid-FEED with a one-cycle reset.
    @(posedge clk); #1;
    start = 1'b1; k_len = KW'(4); bias = '0;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      a_vec[i] = a_mem[0][i];
      b_vec[i] = b_mem[0][i];
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 0;
    repeat (3 * N) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_output", seen, 0);

    push_model(4, '0);
    run_job(4, '0, 1'b0, 0, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
